ct_biu_rd_resp_router: RTL and testbench

//  Read-data (R) channel return path of the BIU. Accepts bus R beats, buffers them in an in-order FIFO,
//  and steers each beat by rid to the IFU (rid[4:1]==4'b1000) or to the LSU (all other ids).

---
 rtl/ct_biu_rd_resp_router.sv | 155 +++++++++++++++
 tb/tb_ct_biu_rd_resp_router.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_biu_rd_resp_router.sv
// ct_biu_rd_resp_router
// R-channel return path of the BIU. Incoming R beats are queued in a small
// in-order FIFO and the head beat is steered by its id to either the IFU
// (rid[4:1] == 4'b1000) or the LSU. A saturating counter tracks how many IFU
// reads are still waiting for their last beat, and a sticky flag records any
// bookkeeping inconsistency between AR handshakes and returned IFU beats.
module ct_biu_rd_resp_router #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 128,
  parameter int IFU_OS = 2
) (
  input  logic                              forever_cpuclk,
  input  logic                              cpurst,
  input  logic                              rvalid,
  output logic                              rready,
  input  logic [4:0]                        rid,
  input  logic [DATA_W-1:0]                 rdata,
  input  logic [3:0]                        rresp,
  input  logic                              rlast,
  input  logic                              arvalid,
  input  logic                              arready,
  input  logic [4:0]                        arid,
  output logic                              biu_ifu_rd_data_vld,
  input  logic                              ifu_biu_rd_data_ready,
  output logic                              biu_ifu_rd_id,
  output logic [DATA_W-1:0]                 biu_ifu_rd_data,
  output logic [3:0]                        biu_ifu_rd_resp,
  output logic                              biu_ifu_rd_last,
  output logic                              biu_lsu_r_vld,
  input  logic                              lsu_biu_r_ready,
  output logic [4:0]                        biu_lsu_r_id,
  output logic [DATA_W-1:0]                 biu_lsu_r_data,
  output logic [3:0]                        biu_lsu_r_resp,
  output logic                              biu_lsu_r_last,
  output logic [$clog2(IFU_OS+1)-1:0]       ifu_rd_outstanding,
  output logic                              biu_rd_idle,
  output logic                              rd_resp_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OS_W  = $clog2(IFU_OS + 1);

  // Beat storage, split per field; payload needs no reset because valid
  // outputs are gated by the occupancy count.
  logic [4:0]        mem_id   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [3:0]        mem_resp [DEPTH];
  logic              mem_last [DEPTH];

  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;

  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              head_is_ifu;
  logic              ifu_pop;
  logic              lsu_pop;
  logic              os_inc;
  logic              os_dec;
  logic              orphan_push;

  logic [4:0]        head_id;
  logic [DATA_W-1:0] head_data;
  logic [3:0]        head_resp;
  logic              head_last;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));

  // rready depends only on registered occupancy, so a full FIFO cannot
  // accept in the same cycle it pops; the slot reopens one cycle later.
  assign rready = !full;
  assign push   = rvalid && rready;

  assign head_id     = mem_id[rptr];
  assign head_data   = mem_data[rptr];
  assign head_resp   = mem_resp[rptr];
  assign head_last   = mem_last[rptr];
  assign head_is_ifu = (head_id[4:1] == 4'b1000);

  assign biu_ifu_rd_data_vld = !empty && head_is_ifu;
  assign biu_lsu_r_vld       = !empty && !head_is_ifu;

  assign biu_ifu_rd_id   = head_id[0];
  assign biu_ifu_rd_data = head_data;
  assign biu_ifu_rd_resp = head_resp;
  assign biu_ifu_rd_last = head_last;

  assign biu_lsu_r_id    = head_id;
  assign biu_lsu_r_data  = head_data;
  assign biu_lsu_r_resp  = head_resp;
  assign biu_lsu_r_last  = head_last;

  assign ifu_pop = biu_ifu_rd_data_vld && ifu_biu_rd_data_ready;
  assign lsu_pop = biu_lsu_r_vld && lsu_biu_r_ready;
  assign pop     = ifu_pop || lsu_pop;

  // The wildcard compare ignores arid[0]: refill and prefetch both count.
  assign os_inc      = arvalid && arready && (arid ==? 5'b1000?);
  assign os_dec      = ifu_pop && head_last;
  assign orphan_push = push && (rid[4:1] == 4'b1000) &&
                       (ifu_rd_outstanding == '0) && !os_inc;

  assign biu_rd_idle = empty && (ifu_rd_outstanding == '0);

  // Capture an accepted beat into the slot at the write pointer.
  always_ff @(posedge forever_cpuclk) begin
    if (push) begin
      mem_id[wptr]   <= rid;
      mem_data[wptr] <= rdata;
      mem_resp[wptr] <= rresp;
      mem_last[wptr] <= rlast;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards any queued beats.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= ptr_next(wptr);
      if (pop)  rptr <= ptr_next(rptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Outstanding IFU read tracking with saturation, plus the sticky error flag.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      ifu_rd_outstanding <= '0;
      rd_resp_err        <= 1'b0;
    end else begin
      if (os_inc && !os_dec) begin
        if (ifu_rd_outstanding == OS_W'(IFU_OS)) rd_resp_err <= 1'b1;
        else ifu_rd_outstanding <= ifu_rd_outstanding + OS_W'(1);
      end else if (os_dec && !os_inc) begin
        if (ifu_rd_outstanding == '0) rd_resp_err <= 1'b1;
        else ifu_rd_outstanding <= ifu_rd_outstanding - OS_W'(1);
      end
      if (orphan_push) rd_resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ct_biu_rd_resp_router.sv
// tb_ct_biu_rd_resp_router
// Table-driven bench: each record holds one cycle of inputs plus the outputs
// expected during that cycle (outputs depend only on registered state), with
// a short hand-written latency sequence at the end.
module tb_ct_biu_rd_resp_router;

  localparam int DATA_W = 128;

  logic              forever_cpuclk;
  logic              cpurst;
  logic              rvalid;
  logic              rready;
  logic [4:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic [3:0]        rresp;
  logic              rlast;
  logic              arvalid;
  logic              arready;
  logic [4:0]        arid;
  logic              biu_ifu_rd_data_vld;
  logic              ifu_biu_rd_data_ready;
  logic              biu_ifu_rd_id;
  logic [DATA_W-1:0] biu_ifu_rd_data;
  logic [3:0]        biu_ifu_rd_resp;
  logic              biu_ifu_rd_last;
  logic              biu_lsu_r_vld;
  logic              lsu_biu_r_ready;
  logic [4:0]        biu_lsu_r_id;
  logic [DATA_W-1:0] biu_lsu_r_data;
  logic [3:0]        biu_lsu_r_resp;
  logic              biu_lsu_r_last;
  logic [1:0]        ifu_rd_outstanding;
  logic              biu_rd_idle;
  logic              rd_resp_err;

  ct_biu_rd_resp_router #(.DEPTH(2), .DATA_W(DATA_W), .IFU_OS(2)) dut (
    .forever_cpuclk        (forever_cpuclk),
    .cpurst                (cpurst),
    .rvalid                (rvalid),
    .rready                (rready),
    .rid                   (rid),
    .rdata                 (rdata),
    .rresp                 (rresp),
    .rlast                 (rlast),
    .arvalid               (arvalid),
    .arready               (arready),
    .arid                  (arid),
    .biu_ifu_rd_data_vld   (biu_ifu_rd_data_vld),
    .ifu_biu_rd_data_ready (ifu_biu_rd_data_ready),
    .biu_ifu_rd_id         (biu_ifu_rd_id),
    .biu_ifu_rd_data       (biu_ifu_rd_data),
    .biu_ifu_rd_resp       (biu_ifu_rd_resp),
    .biu_ifu_rd_last       (biu_ifu_rd_last),
    .biu_lsu_r_vld         (biu_lsu_r_vld),
    .lsu_biu_r_ready       (lsu_biu_r_ready),
    .biu_lsu_r_id          (biu_lsu_r_id),
    .biu_lsu_r_data        (biu_lsu_r_data),
    .biu_lsu_r_resp        (biu_lsu_r_resp),
    .biu_lsu_r_last        (biu_lsu_r_last),
    .ifu_rd_outstanding    (ifu_rd_outstanding),
    .biu_rd_idle           (biu_rd_idle),
    .rd_resp_err           (rd_resp_err)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [4:0]  rid;
    logic [15:0] rd;
    logic [3:0]  rresp;
    logic        rlast;
    logic        arv;
    logic        arr;
    logic [4:0]  arid;
    logic        ir;
    logic        lr;
    logic        e_rr;
    logic        e_iv;
    logic        e_lv;
    logic [1:0]  e_os;
    logic        e_idle;
    logic        e_err;
    logic [4:0]  e_id;
    logic [15:0] e_d;
    logic [3:0]  e_resp;
    logic        e_last;
  } vec_t;

  vec_t vecs[$];
  vec_t stage;
  int   n_vec;
  int   n_miss;

  // Free-running clock.
  initial forever_cpuclk = 1'b0;
  always #5 forever_cpuclk = ~forever_cpuclk;

  task automatic vin(input logic rst_i, input logic rv_i, input logic [4:0] rid_i,
                     input logic [15:0] rd_i, input logic [3:0] rresp_i, input logic rlast_i,
                     input logic arv_i, input logic arr_i, input logic [4:0] arid_i,
                     input logic ir_i, input logic lr_i);
    stage.rst = rst_i; stage.rv = rv_i; stage.rid = rid_i; stage.rd = rd_i;
    stage.rresp = rresp_i; stage.rlast = rlast_i; stage.arv = arv_i; stage.arr = arr_i;
    stage.arid = arid_i; stage.ir = ir_i; stage.lr = lr_i;
  endtask

  task automatic vex(input logic rr_i, input logic iv_i, input logic lv_i, input logic [1:0] os_i,
                     input logic idle_i, input logic err_i, input logic [4:0] id_i,
                     input logic [15:0] d_i, input logic [3:0] resp_i, input logic last_i);
    stage.e_rr = rr_i; stage.e_iv = iv_i; stage.e_lv = lv_i; stage.e_os = os_i;
    stage.e_idle = idle_i; stage.e_err = err_i; stage.e_id = id_i; stage.e_d = d_i;
    stage.e_resp = resp_i; stage.e_last = last_i;
    vecs.push_back(stage);
  endtask

  task automatic applyStimulus(input vec_t v);
    cpurst                = v.rst;
    rvalid                = v.rv;
    rid                   = v.rid;
    rdata                 = {8{v.rd}};
    rresp                 = v.rresp;
    rlast                 = v.rlast;
    arvalid               = v.arv;
    arready               = v.arr;
    arid                  = v.arid;
    ifu_biu_rd_data_ready = v.ir;
    lsu_biu_r_ready       = v.lr;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    logic [6:0]   got_st;
    logic [6:0]   exp_st;
    logic [137:0] got_pl;
    logic [137:0] exp_pl;
    got_st = {rready, biu_ifu_rd_data_vld, biu_lsu_r_vld, ifu_rd_outstanding, biu_rd_idle, rd_resp_err};
    exp_st = {v.e_rr, v.e_iv, v.e_lv, v.e_os, v.e_idle, v.e_err};
    n_vec++;
    if (got_st !== exp_st) begin
      n_miss++;
      $display("[TB] FAIL vec%0d status {rr,iv,lv,os,idle,err} got %b want %b", idx, got_st, exp_st);
    end
    exp_pl = {v.e_id, {8{v.e_d}}, v.e_resp, v.e_last};
    if (v.e_iv) begin
      got_pl = {4'b1000, biu_ifu_rd_id, biu_ifu_rd_data, biu_ifu_rd_resp, biu_ifu_rd_last};
      n_vec++;
      if (got_pl !== exp_pl) begin
        n_miss++;
        $display("[TB] FAIL vec%0d ifu_payload got %h want %h", idx, got_pl, exp_pl);
      end
    end
    if (v.e_lv) begin
      got_pl = {biu_lsu_r_id, biu_lsu_r_data, biu_lsu_r_resp, biu_lsu_r_last};
      n_vec++;
      if (got_pl !== exp_pl) begin
        n_miss++;
        $display("[TB] FAIL vec%0d lsu_payload got %h want %h", idx, got_pl, exp_pl);
      end
    end
  endtask

  // Build the vector table, run it, then the hand-written latency check.
  initial begin
    int cycles;
    n_vec  = 0;
    n_miss = 0;

    // Reset state after reset
    vin(0,0,5'b00000,16'h0000,4'h0,0, 0,0,5'b00000, 0,0); vex(1,0,0,2'd0,1,0, 5'b00000,16'h0000,4'h0,0);
    // One IFU AR, four IFU beats, each delivered one cycle after push
    vin(0,0,5'b00000,16'h0000,4'h0,0, 1,1,5'b10000, 1,0); vex(1,0,0,2'd0,1,0, 5'b00000,16'h0000,4'h0,0);
    vin(0,1,5'b10000,16'hA001,4'h0,0, 0,0,5'b00000, 1,0); vex(1,0,0,2'd1,0,0, 5'b00000,16'h0000,4'h0,0);
    vin(0,1,5'b10000,16'hA002,4'h0,0, 0,0,5'b00000, 1,0); vex(1,1,0,2'd1,0,0, 5'b10000,16'hA001,4'h0,0);
    vin(0,1,5'b10000,16'hA003,4'h0,0, 0,0,5'b00000, 1,0); vex(1,1,0,2'd1,0,0, 5'b10000,16'hA002,4'h0,0);
    vin(0,1,5'b10000,16'hA004,4'h0,1, 0,0,5'b00000, 1,0); vex(1,1,0,2'd1,0,0, 5'b10000,16'hA003,4'h0,0);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 0,0,5'b00000, 1,0); vex(1,1,0,2'd1,0,0, 5'b10000,16'hA004,4'h0,1);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 0,0,5'b00000, 0,0); vex(1,0,0,2'd0,1,0, 5'b00000,16'h0000,4'h0,0);
    // LSU beat blocks the following IFU beat; FIFO fills and rejects a third beat
    vin(0,0,5'b00000,16'h0000,4'h0,0, 1,1,5'b10001, 1,0); vex(1,0,0,2'd0,1,0, 5'b00000,16'h0000,4'h0,0);
    vin(0,1,5'b00011,16'hB001,4'h2,1, 0,0,5'b00000, 1,0); vex(1,0,0,2'd1,0,0, 5'b00000,16'h0000,4'h0,0);
    vin(0,1,5'b10001,16'hB002,4'h0,1, 0,0,5'b00000, 1,0); vex(1,0,1,2'd1,0,0, 5'b00011,16'hB001,4'h2,1);
    vin(0,1,5'b00101,16'hB003,4'h0,1, 0,0,5'b00000, 1,0); vex(0,0,1,2'd1,0,0, 5'b00011,16'hB001,4'h2,1);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 0,0,5'b00000, 1,0); vex(0,0,1,2'd1,0,0, 5'b00011,16'hB001,4'h2,1);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 0,0,5'b00000, 1,0); vex(0,0,1,2'd1,0,0, 5'b00011,16'hB001,4'h2,1);
    vin(0,1,5'b00101,16'hB003,4'h0,1, 0,0,5'b00000, 0,1); vex(0,0,1,2'd1,0,0, 5'b00011,16'hB001,4'h2,1);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 0,0,5'b00000, 0,1); vex(1,1,0,2'd1,0,0, 5'b10001,16'hB002,4'h0,1);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 0,0,5'b00000, 1,0); vex(1,1,0,2'd1,0,0, 5'b10001,16'hB002,4'h0,1);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 0,0,5'b00000, 1,1); vex(1,0,0,2'd0,1,0, 5'b00000,16'h0000,4'h0,0);
    // Back-to-back LSU beats at one per cycle
    vin(0,1,5'b00010,16'hC001,4'h0,0, 0,0,5'b00000, 1,1); vex(1,0,0,2'd0,1,0, 5'b00000,16'h0000,4'h0,0);
    vin(0,1,5'b00100,16'hC002,4'h1,0, 0,0,5'b00000, 1,1); vex(1,0,1,2'd0,0,0, 5'b00010,16'hC001,4'h0,0);
    vin(0,1,5'b00111,16'hC003,4'h0,1, 0,0,5'b00000, 1,1); vex(1,0,1,2'd0,0,0, 5'b00100,16'hC002,4'h1,0);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 0,0,5'b00000, 1,1); vex(1,0,1,2'd0,0,0, 5'b00111,16'hC003,4'h0,1);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 0,0,5'b00000, 1,1); vex(1,0,0,2'd0,1,0, 5'b00000,16'h0000,4'h0,0);
    // IFU beat with nothing outstanding: delivered, counter held, error sticks until reset
    vin(0,1,5'b10000,16'hD001,4'h3,1, 0,0,5'b00000, 0,0); vex(1,0,0,2'd0,1,0, 5'b00000,16'h0000,4'h0,0);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 0,0,5'b00000, 0,0); vex(1,1,0,2'd0,0,1, 5'b10000,16'hD001,4'h3,1);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 0,0,5'b00000, 1,0); vex(1,1,0,2'd0,0,1, 5'b10000,16'hD001,4'h3,1);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 0,0,5'b00000, 0,0); vex(1,0,0,2'd0,1,1, 5'b00000,16'h0000,4'h0,0);
    vin(1,0,5'b00000,16'h0000,4'h0,0, 0,0,5'b00000, 0,0); vex(1,0,0,2'd0,1,1, 5'b00000,16'h0000,4'h0,0);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 0,0,5'b00000, 0,0); vex(1,0,0,2'd0,1,0, 5'b00000,16'h0000,4'h0,0);
    // AR without arready and AR with a non-IFU id do not count
    vin(0,0,5'b00000,16'h0000,4'h0,0, 1,0,5'b10000, 0,0); vex(1,0,0,2'd0,1,0, 5'b00000,16'h0000,4'h0,0);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 1,1,5'b00001, 0,0); vex(1,0,0,2'd0,1,0, 5'b00000,16'h0000,4'h0,0);
    // Simultaneous inc and dec, then saturation at IFU_OS
    vin(0,0,5'b00000,16'h0000,4'h0,0, 1,1,5'b10000, 0,0); vex(1,0,0,2'd0,1,0, 5'b00000,16'h0000,4'h0,0);
    vin(0,1,5'b10000,16'hE001,4'h0,1, 0,0,5'b00000, 0,0); vex(1,0,0,2'd1,0,0, 5'b00000,16'h0000,4'h0,0);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 1,1,5'b10001, 1,0); vex(1,1,0,2'd1,0,0, 5'b10000,16'hE001,4'h0,1);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 1,1,5'b10000, 1,0); vex(1,0,0,2'd1,0,0, 5'b00000,16'h0000,4'h0,0);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 1,1,5'b10000, 0,0); vex(1,0,0,2'd2,0,0, 5'b00000,16'h0000,4'h0,0);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 0,0,5'b00000, 0,0); vex(1,0,0,2'd2,0,1, 5'b00000,16'h0000,4'h0,0);
    // Reset with a beat in flight discards it
    vin(0,1,5'b00001,16'hF001,4'h0,0, 0,0,5'b00000, 0,0); vex(1,0,0,2'd2,0,1, 5'b00000,16'h0000,4'h0,0);
    vin(1,0,5'b00000,16'h0000,4'h0,0, 0,0,5'b00000, 0,0); vex(1,0,1,2'd2,0,1, 5'b00001,16'hF001,4'h0,0);
    vin(0,0,5'b00000,16'h0000,4'h0,0, 0,0,5'b00000, 0,0); vex(1,0,0,2'd0,1,0, 5'b00000,16'h0000,4'h0,0);

    // Initial reset
    cpurst = 1'b1; rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
    arvalid = 1'b0; arready = 1'b0; arid = '0;
    ifu_biu_rd_data_ready = 1'b0; lsu_biu_r_ready = 1'b0;
    repeat (2) @(negedge forever_cpuclk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput(i, vecs[i]);
      @(negedge forever_cpuclk);
    end

    // Push latency: an LSU beat must appear exactly one cycle after its push
    cpurst = 1'b0; rvalid = 1'b1; rid = 5'b00110; rdata = {8{16'h6001}}; rresp = 4'h0; rlast = 1'b1;
    lsu_biu_r_ready = 1'b0; ifu_biu_rd_data_ready = 1'b0; arvalid = 1'b0; arready = 1'b0;
    @(negedge forever_cpuclk);
    rvalid = 1'b0;
    cycles = 1;
    while (!biu_lsu_r_vld && cycles < 4) begin
      @(negedge forever_cpuclk);
      cycles++;
    end
    n_vec++;
    if (cycles != 1 || !biu_lsu_r_vld) begin
      n_miss++;
      $display("[TB] FAIL latency cycles got %0d (vld=%b) want 1 (vld=1)", cycles, biu_lsu_r_vld);
    end
    n_vec++;
    if (biu_lsu_r_data !== {8{16'h6001}} || biu_lsu_r_id !== 5'b00110) begin
      n_miss++;
      $display("[TB] FAIL latency_payload got id=%b data=%h want id=00110 data=%h",
               biu_lsu_r_id, biu_lsu_r_data, {8{16'h6001}});
    end
    lsu_biu_r_ready = 1'b1;
    @(negedge forever_cpuclk);
    n_vec++;
    if (biu_rd_idle !== 1'b1 || biu_lsu_r_vld !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL drain_idle got idle=%b vld=%b want idle=1 vld=0", biu_rd_idle, biu_lsu_r_vld);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
